// File: rtl/riscv_pkg.sv
// Shared constants and types for the core data-memory responder.
// MMIO register offsets are byte offsets inside the MMIO window.
package riscv_pkg;

    localparam logic [3:0] MMIO_BASE_DEF = 4'hF;

    localparam int CYCLE_OFS   = 'h00;
    localparam int TOHOST_OFS  = 'h04;
    localparam int SCRATCH_OFS = 'h08;

    typedef logic [31:0] dmem_word_t;

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register window: cycle counter, scratch, tohost and registered read mux.
// Built only when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFS_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [OFS_WIDTH-1:0]  i_ofs,
    input  logic [DATA_WIDTH-1:0] i_wrdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_tohost_valid,
    output logic [DATA_WIDTH-1:0] o_tohost_data
);

    localparam int WW = OFS_WIDTH - 2;
    localparam logic [WW-1:0] CYC_IDX = WW'(CYCLE_OFS / 4);
    localparam logic [WW-1:0] TH_IDX  = WW'(TOHOST_OFS / 4);
    localparam logic [WW-1:0] SCR_IDX = WW'(SCRATCH_OFS / 4);

    logic [WW-1:0]         widx;
    logic                  unused_lsb;
    logic                  hit_cyc;
    logic                  hit_th;
    logic                  hit_scr;
    logic                  wr_th;
    logic                  wr_scr;
    logic [DATA_WIDTH-1:0] cycle_q;
    logic [DATA_WIDTH-1:0] scratch_q;
    logic [DATA_WIDTH-1:0] tohost_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign widx       = i_ofs[OFS_WIDTH-1:2];
    assign unused_lsb = ^i_ofs[1:0];
    assign hit_cyc    = (widx == CYC_IDX);
    assign hit_th     = (widx == TH_IDX);
    assign hit_scr    = (widx == SCR_IDX);
    assign wr_th      = i_sel & i_we & hit_th;
    assign wr_scr     = i_sel & i_we & hit_scr;

    // Scratch reads are write-first, matching the RAM behaviour.
    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            hit_cyc: rdata_d = cycle_q;
            hit_th:  rdata_d = tohost_q;
            hit_scr: rdata_d = wr_scr ? i_wrdata : scratch_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            tohost_q  <= '0;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            valid_q <= wr_th;
            rdata_q <= rdata_d;
            if (wr_th) begin
                tohost_q <= i_wrdata;
            end
            if (wr_scr) begin
                scratch_q <= i_wrdata;
            end
        end
    end

    assign o_rdata        = rdata_q;
    assign o_tohost_valid = valid_q;
    assign o_tohost_data  = tohost_q;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with 1-cycle write-first reads.
// Define DMEM_MMIO_EN to add the MMIO window (cycle, tohost, scratch).
module data_mem_resp
    import riscv_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 12,
    parameter logic [3:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr_mem,
    input  logic [DATA_WIDTH-1:0] i_wrdata_mem,
    input  logic                  i_we_mem,
    output logic [DATA_WIDTH-1:0] o_rdata_mem,
    output logic                  o_tohost_valid,
    output logic [DATA_WIDTH-1:0] o_tohost_data
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         idx;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata_q;
    logic                  unused_lsb;

    assign idx        = i_addr_mem[ADDR_WIDTH-1:2];
    assign unused_lsb = ^i_addr_mem[1:0];

`ifdef DMEM_MMIO_EN
    logic                  mmio_sel;
    logic                  mmio_sel_q;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    assign mmio_sel = (i_addr_mem[ADDR_WIDTH-1:ADDR_WIDTH-4] == MMIO_BASE);
    assign ram_we   = i_we_mem & ~mmio_sel;

    dmem_mmio_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFS_WIDTH  (ADDR_WIDTH - 4)
    ) u_regs (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_sel          (mmio_sel),
        .i_we           (i_we_mem),
        .i_ofs          (i_addr_mem[ADDR_WIDTH-5:0]),
        .i_wrdata       (i_wrdata_mem),
        .o_rdata        (mmio_rdata),
        .o_tohost_valid (o_tohost_valid),
        .o_tohost_data  (o_tohost_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mmio_sel_q <= 1'b0;
        end else begin
            mmio_sel_q <= mmio_sel;
        end
    end

    assign o_rdata_mem = mmio_sel_q ? mmio_rdata : ram_rdata_q;
`else
    logic [3:0] unused_base;

    assign unused_base    = MMIO_BASE;
    assign ram_we         = i_we_mem;
    assign o_rdata_mem    = ram_rdata_q;
    assign o_tohost_valid = 1'b0;
    assign o_tohost_data  = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[idx] <= i_wrdata_mem;
        end
    end

    // A store to the addressed word forwards its data (write-first).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ram_rdata_q <= '0;
        end else begin
            ram_rdata_q <= ram_we ? i_wrdata_mem : mem[idx];
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (both DMEM_MMIO_EN builds).
module tb_data_mem_resp;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] addr = '0;
    dmem_word_t  wdata = '0;
    logic        we = 1'b0;
    dmem_word_t  rdata;
    dmem_word_t  th_data;
    logic        th_valid;

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc;
    dmem_word_t  exp_q[$];
    dmem_word_t  e;

    data_mem_resp dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_addr_mem     (addr),
        .i_wrdata_mem   (wdata),
        .i_we_mem       (we),
        .o_rdata_mem    (rdata),
        .o_tohost_valid (th_valid),
        .o_tohost_data  (th_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic drive(input logic [11:0] a, input logic w,
                         input dmem_word_t d);
        addr  = a;
        we    = w;
        wdata = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(12'h000, 1'b0, '0);
        drive(12'h000, 1'b0, '0);
        n_chk++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h exp 0", rdata);
        end
        n_chk++;
        if (th_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b exp 0", th_valid);
        end
        n_chk++;
        if (th_data !== '0) begin
            n_fail++;
            $display("FAIL reset_tohost got %h exp 0", th_data);
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL release_rdata got %h exp 0", rdata);
        end
        @(negedge clk);
        drive(12'h000, 1'b0, '0);
        drive(12'h000, 1'b0, '0);
        n_chk++;
        if (th_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid got %b exp 0", th_valid);
        end
`ifdef DMEM_MMIO_EN
        exp_q.push_back(dmem_word_t'(cyc));
        drive(12'hF00, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL cycle_read got %h exp %h", rdata, e);
        end
        repeat (5) drive(12'h000, 1'b0, '0);
        exp_q.push_back(dmem_word_t'(cyc));
        drive(12'hF00, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL cycle_read2 got %h exp %h", rdata, e);
        end
`endif
    endtask

    task automatic test_ram_rw();
        dmem_word_t d [8];
        drive(12'h010, 1'b1, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        drive(12'h010, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL ram_read got %h exp %h", rdata, e);
        end
    endtask

    task automatic test_back_to_back();
        dmem_word_t d [8];
        for (int i = 0; i < 8; i++) begin
            d[i] = $urandom;
            drive(12'(12'h200 + i * 4), 1'b1, d[i]);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            drive(12'(12'h200 + i * 4), 1'b0, '0);
            e = exp_q.pop_front();
            n_chk++;
            if (rdata !== e) begin
                n_fail++;
                $display("FAIL b2b_read[%0d] got %h exp %h", i, rdata, e);
            end
        end
    endtask

    task automatic test_write_first();
        drive(12'h020, 1'b1, '0);
        exp_q.push_back(32'h12345678);
        drive(12'h020, 1'b1, 32'h12345678);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL write_first got %h exp %h", rdata, e);
        end
        exp_q.push_back(32'h12345678);
        drive(12'h020, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL wf_hold got %h exp %h", rdata, e);
        end
    endtask

    task automatic test_misaligned();
        drive(12'h010, 1'b1, 32'hA5A5A5A5);
        exp_q.push_back(32'hA5A5A5A5);
        drive(12'h013, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL misaligned_rd got %h exp %h", rdata, e);
        end
        drive(12'h016, 1'b1, 32'h0F0F0F0F);
        exp_q.push_back(32'h0F0F0F0F);
        drive(12'h014, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL misaligned_wr got %h exp %h", rdata, e);
        end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        drive(12'h104, 1'b1, 32'h55AA55AA);
        drive(12'hF04, 1'b1, 32'h1);
        n_chk++;
        if (th_valid !== 1'b1 || th_data !== 32'h1) begin
            n_fail++;
            $display("FAIL tohost_pulse got %b/%h exp 1/1",
                     th_valid, th_data);
        end
        drive(12'h000, 1'b0, '0);
        n_chk++;
        if (th_valid !== 1'b0 || th_data !== 32'h1) begin
            n_fail++;
            $display("FAIL tohost_drop got %b/%h exp 0/1",
                     th_valid, th_data);
        end
        exp_q.push_back(32'h55AA55AA);
        drive(12'h104, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL ram_unshadowed got %h exp %h", rdata, e);
        end
        exp_q.push_back(32'h1);
        drive(12'hF04, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL tohost_read got %h exp %h", rdata, e);
        end
        drive(12'hF04, 1'b1, 32'h2);
        n_chk++;
        if (th_valid !== 1'b1 || th_data !== 32'h2) begin
            n_fail++;
            $display("FAIL tohost_b2b1 got %b/%h exp 1/2",
                     th_valid, th_data);
        end
        drive(12'hF04, 1'b1, 32'h3);
        n_chk++;
        if (th_valid !== 1'b1 || th_data !== 32'h3) begin
            n_fail++;
            $display("FAIL tohost_b2b2 got %b/%h exp 1/3",
                     th_valid, th_data);
        end
        drive(12'h000, 1'b0, '0);
        n_chk++;
        if (th_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tohost_b2b_end got %b exp 0", th_valid);
        end
        drive(12'hF08, 1'b1, 32'hCAFE);
        exp_q.push_back(32'hCAFE);
        drive(12'hF08, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL scratch_read got %h exp %h", rdata, e);
        end
        exp_q.push_back(32'hBEEF);
        drive(12'hF08, 1'b1, 32'hBEEF);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL scratch_wf got %h exp %h", rdata, e);
        end
        drive(12'hF0C, 1'b1, 32'hFFFFFFFF);
        exp_q.push_back(32'h0);
        drive(12'hF0C, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL other_zero got %h exp %h", rdata, e);
        end
        drive(12'hF00, 1'b1, 32'h00ABCDEF);
        exp_q.push_back(dmem_word_t'(cyc));
        drive(12'hF00, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL cycle_ro got %h exp %h", rdata, e);
        end
        drive(12'hF08, 1'b1, 32'hCAFE);
    endtask
`else
    task automatic test_no_mmio();
        drive(12'hF04, 1'b1, 32'h77);
        n_chk++;
        if (th_valid !== 1'b0 || th_data !== '0) begin
            n_fail++;
            $display("FAIL no_tohost got %b/%h exp 0/0",
                     th_valid, th_data);
        end
        exp_q.push_back(32'h77);
        drive(12'hF04, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL f04_ram got %h exp %h", rdata, e);
        end
        drive(12'hF00, 1'b1, 32'h00ABCDEF);
        drive(12'h000, 1'b0, '0);
        exp_q.push_back(32'h00ABCDEF);
        drive(12'hF00, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL f00_ram got %h exp %h", rdata, e);
        end
        drive(12'h030, 1'b1, 32'hCAFE);
    endtask
`endif

    task automatic test_reset_mid();
        logic [11:0] a;
`ifdef DMEM_MMIO_EN
        a = 12'hF08;
`else
        a = 12'h030;
`endif
        exp_q.push_back(32'hCAFE);
        drive(a, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL pre_reset got %h exp %h", rdata, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (rdata !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_rdata got %h exp 0", rdata);
        end
        n_chk++;
        if (th_valid !== 1'b0 || th_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_tohost got %b/%h exp 0/0",
                     th_valid, th_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DMEM_MMIO_EN
        exp_q.push_back(32'h0);
        drive(12'hF08, 1'b0, '0);
        e = exp_q.pop_front();
        n_chk++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL scratch_cleared got %h exp %h", rdata, e);
        end
`else
        drive(12'h000, 1'b0, '0);
`endif
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_write_first();
        test_misaligned();
`ifdef DMEM_MMIO_EN
        test_mmio();
`else
        test_no_mmio();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
